// File: rtl/ysyx_22050133_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050133_issue_scoreboard
// Purpose  : In-order issue scoreboard. Tracks pending register writes per
//            architectural register, blocks issue on RAW hazards or when write
//            tracking resources are exhausted, and supports a fence drain and
//            a pipeline flush.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            id_valid, id_rs1/2, id_rs*_used, id_rd, id_rd_wen - decode request
//            id_ready, issue               - issue handshake
//            wb_valid, wb_rd               - writeback retirement
//            flush                         - discard all in-flight writes
//            fence_req, fence_done         - drain request / completion pulse
//            inflight                      - number of outstanding writes
//            stall_cnt                     - cycles with id_valid & ~id_ready
//            wb_err                        - sticky unmatched-writeback flag
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22050133_issue_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_wen,
    output logic        id_ready,
    output logic        issue,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    input  logic        fence_req,
    output logic        fence_done,
    output logic [2:0]  inflight,
    output logic [31:0] stall_cnt,
    output logic        wb_err
);

    localparam logic [CNT_W-1:0] C_PEND_MAX     = {CNT_W{1'b1}};
    localparam logic [2:0]       C_MAX_INFLIGHT = 3'(MAX_INFLIGHT);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_fence_done_next;

    logic [CNT_W-1:0]   r_pend [0:31];
    logic [2:0]         r_inflight;
    logic [31:0]        r_stall_cnt;
    logic               r_wb_err;
    logic               r_fence_done;

    logic               w_raw;
    logic               w_struct;
    logic               w_inc;
    logic               w_wb_hit;
    logic               w_dec;
    logic               w_same_reg;

    // ------------------------------------------------------------------
    // Hazard detection: only registered state and current decode inputs.
    // Entry 0 is held at zero, so x0 sources never look pending.
    // ------------------------------------------------------------------
    always_comb begin
        w_raw    = (id_rs1_used && (id_rs1 != 5'd0) && (r_pend[id_rs1] != '0)) ||
                   (id_rs2_used && (id_rs2 != 5'd0) && (r_pend[id_rs2] != '0));
        w_struct = id_rd_wen && (id_rd != 5'd0) &&
                   ((r_pend[id_rd] == C_PEND_MAX) || (r_inflight == C_MAX_INFLIGHT));
        id_ready = !rst && (r_state == RUN) && !flush && !w_raw && !w_struct;
        issue    = id_valid && id_ready;
    end

    // Counter update requests. A flush suppresses writeback effects entirely.
    assign w_inc      = issue && id_rd_wen && (id_rd != 5'd0);
    assign w_wb_hit   = wb_valid && (wb_rd != 5'd0) && !flush;
    assign w_dec      = w_wb_hit && (r_pend[wb_rd] != '0);
    // Issue and retirement on the same register cancel out.
    assign w_same_reg = w_inc && w_dec && (id_rd == wb_rd);

    // ------------------------------------------------------------------
    // Per-register pending counters
    // ------------------------------------------------------------------
    generate
        for (genvar r = 0; r < 32; r++) begin : g_pend
            if (r == 0) begin : g_zero
                always_ff @(posedge clk) begin
                    r_pend[r] <= '0;
                end
            end else begin : g_reg
                always_ff @(posedge clk) begin
                    if (rst || flush) begin
                        r_pend[r] <= '0;
                    end else if (!w_same_reg) begin
                        if (w_inc && (id_rd == 5'(r))) begin
                            r_pend[r] <= r_pend[r] + 1'b1;
                        end else if (w_dec && (wb_rd == 5'(r))) begin
                            r_pend[r] <= r_pend[r] - 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Aggregate counters and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_inflight <= 3'd0;
        end else begin
            r_inflight <= r_inflight + {2'd0, w_inc} - {2'd0, w_dec};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_wb_err    <= 1'b0;
        end else begin
            if (id_valid && !id_ready && !flush) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_wb_hit && (r_pend[wb_rd] == '0)) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fence FSM. The drain exits on the edge where the registered inflight
    // count is zero, or immediately on a flush; fence_done is registered so
    // it appears in the cycle after the exit edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_fence_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fence_done <= w_fence_done_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_fence_done_next = 1'b0;
        case (r_state)
            RUN: begin
                if (fence_req && !flush) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (flush || (r_inflight == 3'd0)) begin
                    w_state_next      = RUN;
                    w_fence_done_next = 1'b1;
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    assign inflight   = r_inflight;
    assign stall_cnt  = r_stall_cnt;
    assign wb_err     = r_wb_err;
    assign fence_done = r_fence_done;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050133_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050133_issue_scoreboard
// Purpose  : Self-checking bench. A table of per-cycle vectors carries the
//            inputs and hand-derived expected outputs; post-edge expectations
//            go through a queue and are compared one cycle later.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22050133_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        id_rs1_used, id_rs2_used, id_rd_wen;
    logic        id_ready, issue;
    logic        wb_valid, flush, fence_req, fence_done, wb_err;
    logic [2:0]  inflight;
    logic [31:0] stall_cnt;

    ysyx_22050133_issue_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen),
        .id_ready(id_ready), .issue(issue),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .fence_req(fence_req), .fence_done(fence_done),
        .inflight(inflight), .stall_cnt(stall_cnt), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [4:0]  rs1;
        logic        rs1u;
        logic [4:0]  rs2;
        logic        rs2u;
        logic [4:0]  rd;
        logic        wen;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        fl;
        logic        fr;
        logic        e_ready;
        logic [2:0]  e_infl;
        logic        e_fd;
        logic        e_err;
        logic [31:0] e_stall;
    } vec_t;

    typedef struct {
        int          idx;
        logic [2:0]  infl;
        logic        fd;
        logic        err;
        logic [31:0] stall;
    } post_t;

    vec_t  vecs[$];
    post_t sb[$];
    int    errors = 0;
    int    checks = 0;

    // v(rst,valid,rs1,rs1u,rs2,rs2u,rd,wen,wbv,wbrd,flush,fence | ready,infl,fd,err,stall)
    function automatic vec_t v(input logic r, input logic vl, input logic [4:0] a,
                               input logic au, input logic [4:0] b, input logic bu,
                               input logic [4:0] d, input logic w, input logic wv,
                               input logic [4:0] wd, input logic f, input logic fr,
                               input logic er, input logic [2:0] ei, input logic efd,
                               input logic ee, input logic [31:0] es);
        vec_t t;
        t.rst = r; t.valid = vl; t.rs1 = a; t.rs1u = au; t.rs2 = b; t.rs2u = bu;
        t.rd = d; t.wen = w; t.wbv = wv; t.wbrd = wd; t.fl = f; t.fr = fr;
        t.e_ready = er; t.e_infl = ei; t.e_fd = efd; t.e_err = ee; t.e_stall = es;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        // reset, read of r5 while resetting must not be ready
        vecs.push_back(v(1,1, 5,1, 0,0, 0,0, 0,0, 0,0,  0,0,0,0,0));   // 0
        // RAW on r5
        vecs.push_back(v(0,1, 0,0, 0,0, 5,1, 0,0, 0,0,  1,1,0,0,0));   // 1 issue rd5
        vecs.push_back(v(0,1, 5,1, 0,0, 0,0, 0,0, 0,0,  0,1,0,0,1));   // 2
        vecs.push_back(v(0,1, 5,1, 0,0, 0,0, 0,0, 0,0,  0,1,0,0,2));   // 3
        vecs.push_back(v(0,1, 5,1, 0,0, 0,0, 1,5, 0,0,  0,0,0,0,3));   // 4 wb r5, still stalled
        vecs.push_back(v(0,1, 5,1, 0,0, 0,0, 0,0, 0,0,  1,0,0,0,3));   // 5
        // fill MAX_INFLIGHT
        vecs.push_back(v(0,1, 0,0, 0,0, 1,1, 0,0, 0,0,  1,1,0,0,3));   // 6
        vecs.push_back(v(0,1, 0,0, 0,0, 2,1, 0,0, 0,0,  1,2,0,0,3));   // 7
        vecs.push_back(v(0,1, 0,0, 0,0, 3,1, 0,0, 0,0,  1,3,0,0,3));   // 8
        vecs.push_back(v(0,1, 0,0, 0,0, 4,1, 0,0, 0,0,  1,4,0,0,3));   // 9
        vecs.push_back(v(0,1, 0,0, 0,0, 6,1, 0,0, 0,0,  0,4,0,0,4));   // 10 5th write blocked
        vecs.push_back(v(0,1, 6,1, 0,1, 6,0, 0,0, 0,0,  1,4,0,0,4));   // 11 non-writing ok
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 1,1, 0,0,  1,3,0,0,4));   // 12
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 1,2, 0,0,  1,2,0,0,4));   // 13
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 1,3, 0,0,  1,1,0,0,4));   // 14
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 1,4, 0,0,  1,0,0,0,4));   // 15
        // same-cycle issue + writeback on r7
        vecs.push_back(v(0,1, 0,0, 0,0, 7,1, 0,0, 0,0,  1,1,0,0,4));   // 16
        vecs.push_back(v(0,1, 0,0, 0,0, 7,1, 1,7, 0,0,  1,1,0,0,4));   // 17
        vecs.push_back(v(0,1, 7,1, 0,0, 0,0, 0,0, 0,0,  0,1,0,0,5));   // 18 pend7 still 1
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 1,7, 0,0,  1,0,0,0,5));   // 19
        vecs.push_back(v(0,1, 7,1, 0,0, 0,0, 0,0, 0,0,  1,0,0,0,5));   // 20
        // pending counter saturation on r8
        vecs.push_back(v(0,1, 0,0, 0,0, 8,1, 0,0, 0,0,  1,1,0,0,5));   // 21
        vecs.push_back(v(0,1, 0,0, 0,0, 8,1, 0,0, 0,0,  1,2,0,0,5));   // 22
        vecs.push_back(v(0,1, 0,0, 0,0, 8,1, 0,0, 0,0,  1,3,0,0,5));   // 23
        vecs.push_back(v(0,1, 0,0, 0,0, 8,1, 0,0, 0,0,  0,3,0,0,6));   // 24 saturated
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 1,8, 0,0,  1,2,0,0,6));   // 25
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 1,8, 0,0,  1,1,0,0,6));   // 26
        // fence with two writes outstanding
        vecs.push_back(v(0,1, 0,0, 0,0,10,1, 0,0, 0,0,  1,2,0,0,6));   // 27
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,2,0,0,6));   // 28 fence_req
        vecs.push_back(v(0,1, 0,0, 0,0, 0,0, 1,8, 0,0,  0,1,0,0,7));   // 29
        vecs.push_back(v(0,1, 0,0, 0,0, 0,0, 1,10,0,0,  0,0,0,0,8));   // 30
        vecs.push_back(v(0,1, 0,0, 0,0, 0,0, 0,0, 0,0,  0,0,1,0,9));   // 31 exit drain
        vecs.push_back(v(0,1, 0,0, 0,0, 0,0, 0,0, 0,0,  1,0,0,0,9));   // 32 pulse ends
        // fence with nothing outstanding
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,0,0,0,9));   // 33
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 0,0, 0,0,  0,0,1,0,9));   // 34
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 0,0, 0,0,  1,0,0,0,9));   // 35
        // unmatched writeback, x0 handling
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 1,9, 0,0,  1,0,0,1,9));   // 36
        vecs.push_back(v(0,1, 0,0, 0,0, 0,1, 0,0, 0,0,  1,0,0,1,9));   // 37 write x0
        vecs.push_back(v(0,1, 0,1, 0,1, 0,0, 0,0, 0,0,  1,0,0,1,9));   // 38 read x0
        // flush while draining, with a repeated fence_req
        vecs.push_back(v(0,1, 0,0, 0,0,11,1, 0,0, 0,0,  1,1,0,1,9));   // 39
        vecs.push_back(v(0,1, 0,0, 0,0,12,1, 0,0, 0,0,  1,2,0,1,9));   // 40
        vecs.push_back(v(0,1, 0,0, 0,0,13,1, 0,0, 0,0,  1,3,0,1,9));   // 41
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,3,0,1,9));   // 42
        vecs.push_back(v(0,1, 0,0, 0,0, 0,0, 0,0, 0,1,  0,3,0,1,10));  // 43
        vecs.push_back(v(0,1, 0,0, 0,0, 0,0, 1,11,1,0,  0,0,1,1,10));  // 44 flush
        vecs.push_back(v(0,1,11,1, 0,0, 0,0, 0,0, 0,0,  1,0,0,1,10));  // 45
        // flush in RUN
        vecs.push_back(v(0,1, 0,0, 0,0,14,1, 0,0, 0,0,  1,1,0,1,10));  // 46
        vecs.push_back(v(0,1, 0,0, 0,0, 0,0, 0,0, 1,0,  0,0,0,1,10));  // 47
        vecs.push_back(v(0,1,14,1, 0,0, 0,0, 0,0, 0,0,  1,0,0,1,10));  // 48
        // reset in the middle of a drain
        vecs.push_back(v(0,1, 0,0, 0,0,15,1, 0,0, 0,0,  1,1,0,1,10));  // 49
        vecs.push_back(v(0,0, 0,0, 0,0, 0,0, 0,0, 0,1,  1,1,0,1,10));  // 50
        vecs.push_back(v(0,1, 0,0, 0,0, 0,0, 0,0, 0,0,  0,1,0,1,11));  // 51
        vecs.push_back(v(1,1, 0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,0,0));   // 52
        vecs.push_back(v(0,1,15,1, 0,0, 0,0, 0,0, 0,0,  1,0,0,0,0));   // 53

        for (int i = 0; i < vecs.size(); i++) begin
            post_t p;
            @(negedge clk);
            rst = vecs[i].rst; id_valid = vecs[i].valid;
            id_rs1 = vecs[i].rs1; id_rs1_used = vecs[i].rs1u;
            id_rs2 = vecs[i].rs2; id_rs2_used = vecs[i].rs2u;
            id_rd = vecs[i].rd; id_rd_wen = vecs[i].wen;
            wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbrd;
            flush = vecs[i].fl; fence_req = vecs[i].fr;
            #1;
            chk("id_ready", i, 32'(id_ready), 32'(vecs[i].e_ready));
            chk("issue", i, 32'(issue), 32'(vecs[i].valid & vecs[i].e_ready));
            p.idx = i; p.infl = vecs[i].e_infl; p.fd = vecs[i].e_fd;
            p.err = vecs[i].e_err; p.stall = vecs[i].e_stall;
            sb.push_back(p);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard step %0d: got empty queue expected entry", i);
            end else begin
                p = sb.pop_front();
                chk("inflight", p.idx, 32'(inflight), 32'(p.infl));
                chk("fence_done", p.idx, 32'(fence_done), 32'(p.fd));
                chk("wb_err", p.idx, 32'(wb_err), 32'(p.err));
                chk("stall_cnt", p.idx, stall_cnt, p.stall);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
